pool2_sequencer: RTL
====================

POOL2_SEQUENCER -- requirements
Module: pool2_sequencer

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, signed feature-element width.
REQ-002 SHALL have parameter CHANNELS, default 2, number of feature-map channels.
REQ-003 SHALL have parameter IN_DIM, default 10, input rows/cols (even); output dim OUT_DIM = IN_DIM/2.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to pool the full map.
REQ-007 SHALL have port hold  input  1  freeze request; no new read issued while high.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse after last write.
REQ-010 SHALL have port rd_en  output  1  feature-buffer read strobe.
REQ-011 SHALL have port rd_addr  output  clog2(CHANNELS*IN_DIM*IN_DIM)  read address = c*IN_DIM*IN_DIM + r*IN_DIM + col.
REQ-012 SHALL have port rd_data  input  BITWIDTH  signed data, valid exactly one cycle after rd_en.
REQ-013 SHALL have port wr_en  output  1  pooled-result write strobe.
REQ-014 SHALL have port wr_addr  output  clog2(CHANNELS*OUT_DIM*OUT_DIM)  write address = c*OUT_DIM*OUT_DIM + i*OUT_DIM + j.
REQ-015 SHALL have port wr_data  output  BITWIDTH  signed max of the 2x2 window.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start, RUN->DRAIN after final read issued, DRAIN->IDLE when done pulses.
REQ-017 start SHALL be ignored when busy is high.
REQ-018 First rd_en SHALL assert the cycle after start is sampled in IDLE (hold low).
REQ-019 Windows SHALL be visited channel-major, then i, then j; within a window read order SHALL be (2i,2j), (2i+1,2j), (2i,2j+1), (2i+1,2j+1).
REQ-020 With hold low, one read SHALL issue per cycle, back-to-back across windows with no bubbles.
REQ-021 hold high SHALL deassert rd_en and freeze address counters; data of a read issued the previous cycle SHALL still be accumulated.
REQ-022 Max SHALL be a signed BITWIDTH comparison; the first datum of a window SHALL load the accumulator unconditionally; ties keep either (equal) value.
REQ-023 wr_en SHALL pulse, registered, one cycle after the fourth datum of a window is on rd_data; wr_addr/wr_data valid only with wr_en.
REQ-024 With no hold, reads occupy cycles 1..4*CHANNELS*OUT_DIM^2 after start (1..200 default), final wr_en at cycle 202, done at 203, busy low from 204.
REQ-025 done SHALL pulse one cycle after the final wr_en; busy SHALL deassert together with that pulse's end.

Reset
REQ-026 rst_n low SHALL, asynchronously, force state IDLE, all counters and accumulator 0, busy/done/rd_en/wr_en 0, rd_addr/wr_addr/wr_data 0.
REQ-027 Reset mid-operation SHALL abort without a done pulse; a new start after release SHALL restart from address 0.

Configuration
REQ-028 Macro POOL2_RELU_EN defined: wr_data SHALL be max(window,0) (negatives clamp to 0); undefined: wr_data SHALL be the raw signed window max.

Verification
REQ-029 Buffer holds value = address (0..199), start, hold low -> 50 writes, wr_addr k gets 11+2*(k%5)*1+... i.e. value c*100+(2i+1)*10+2j+1 (first write 11, last 199), done at cycle 203.
REQ-030 Window (0,0) values -5,-9,-2,-7 -> wr_data -2 (RELU off), 0 (POOL2_RELU_EN defined).
REQ-031 hold high for 3 cycles during window 7 -> rd_en low those cycles, results identical to REQ-029, done at cycle 206.
REQ-032 start pulsed at cycle 50 while busy -> ignored; exactly 50 writes, single done.
REQ-033 rst_n low at cycle 100 -> all outputs 0 immediately, no done; restart -> full correct 50-write sequence.
REQ-034 Window containing 32'h7FFFFFFF and 32'h80000000 -> wr_data 32'h7FFFFFFF (signed compare).

Source files
------------

// File: rtl/pool2_sequencer.sv
// 2x2 max-pool sequencer: walks a CHANNELS x IN_DIM x IN_DIM feature buffer and writes window maxima.
// Latency: first read 1 cycle after start, each write 2 cycles after its window's last read, done 1 cycle after last write.
// Backpressure: hold stalls read issue and counters; in-flight reads still complete. Define POOL2_RELU_EN to clamp outputs at 0.
module pool2_sequencer #(
    parameter int BITWIDTH = 32,
    parameter int CHANNELS = 2,
    parameter int IN_DIM   = 10,
    localparam int OUT_DIM = IN_DIM / 2,
    localparam int AW      = $clog2(CHANNELS * IN_DIM * IN_DIM),
    localparam int WAW     = $clog2(CHANNELS * OUT_DIM * OUT_DIM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                hold,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [AW-1:0]       rd_addr,
    input  logic [BITWIDTH-1:0] rd_data,
    output logic                wr_en,
    output logic [WAW-1:0]      wr_addr,
    output logic [BITWIDTH-1:0] wr_data
);
    localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OW   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int NWIN = CHANNELS * OUT_DIM * OUT_DIM;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              r_state;
    logic                r_busy, r_done, r_rd_en, r_wr_en;
    logic [AW-1:0]       r_rd_addr;
    logic [WAW-1:0]      r_wr_addr, r_rd_waddr, r_d_waddr;
    logic [BITWIDTH-1:0] r_wr_data, r_acc;
    logic [CW-1:0]       r_c;
    logic [OW-1:0]       r_i, r_j;
    logic [1:0]          r_q, r_rd_q, r_d_q;
    logic                r_d_vld;

    logic                w_issue, w_last_rd;
    logic [AW-1:0]       w_rd_addr;
    logic [WAW-1:0]      w_wr_addr;
    logic [BITWIDTH-1:0] w_max, w_out;

    assign w_issue   = ((r_state == IDLE && start) || r_state == RUN) && !hold;
    assign w_last_rd = (r_q == 2'd3) && (r_j == OW'(OUT_DIM - 1)) &&
                       (r_i == OW'(OUT_DIM - 1)) && (r_c == CW'(CHANNELS - 1));

    // q[0] selects the odd row, q[1] the odd column of the window.
    assign w_rd_addr = AW'(r_c) * AW'(IN_DIM * IN_DIM) + AW'({r_i, r_q[0]}) * AW'(IN_DIM)
                     + AW'({r_j, r_q[1]});
    assign w_wr_addr = WAW'(r_c) * WAW'(OUT_DIM * OUT_DIM) + WAW'(r_i) * WAW'(OUT_DIM) + WAW'(r_j);

    assign w_max = (r_d_q == 2'd0) ? rd_data :
                   (($signed(rd_data) > $signed(r_acc)) ? rd_data : r_acc);
`ifdef POOL2_RELU_EN
    assign w_out = w_max[BITWIDTH-1] ? '0 : w_max;
`else
    assign w_out = w_max;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_q     <= '0;
            r_rd_waddr <= '0;
            r_c        <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_q        <= '0;
            r_d_vld    <= 1'b0;
            r_d_q      <= '0;
            r_d_waddr  <= '0;
            r_acc      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= RUN;
                    r_busy  <= 1'b1;
                end
                RUN: if (w_issue && w_last_rd) r_state <= DRAIN;
                DRAIN: begin
                    if (r_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_wr_en && r_wr_addr == WAW'(NWIN - 1)) begin
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            r_rd_en <= w_issue;
            if (w_issue) begin
                r_rd_addr  <= w_rd_addr;
                r_rd_q     <= r_q;
                r_rd_waddr <= w_wr_addr;
                r_q        <= r_q + 2'd1;
                if (r_q == 2'd3) begin
                    if (r_j == OW'(OUT_DIM - 1)) begin
                        r_j <= '0;
                        if (r_i == OW'(OUT_DIM - 1)) begin
                            r_i <= '0;
                            r_c <= (r_c == CW'(CHANNELS - 1)) ? '0 : r_c + 1'b1;
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
            end

            // Stage aligned with rd_data: tags of the read issued last cycle.
            r_d_vld   <= r_rd_en;
            r_d_q     <= r_rd_q;
            r_d_waddr <= r_rd_waddr;

            r_wr_en <= 1'b0;
            if (r_d_vld) begin
                r_acc <= w_max;
                if (r_d_q == 2'd3) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_d_waddr;
                    r_wr_data <= w_out;
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
endmodule
